toss_game_ctrl: RTL and testbench
=================================

TOSS_GAME_CTRL -- requirements
Module: toss_game_ctrl

Interface
REQ-001 Parameter MAX_PLAYERS, default 4, meaning number of per-player streak counters; fixed at 4 for this release.
REQ-002 Parameter STREAK_W, default 3, meaning width of each streak counter and of the target value.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a game; sampled only in IDLE.
REQ-006 abort  input  1  end the current game without a winner.
REQ-007 cfg_players  input  2  number of players minus 1 (0..3 gives 1..4 players); latched on start.
REQ-008 cfg_target  input  STREAK_W  consecutive heads needed to win; latched on start; 0 is treated as 1.
REQ-009 toss_valid  input  1  a toss result is presented.
REQ-010 toss  input  1  toss result: 1 = head, 0 = tail.
REQ-011 toss_ready  output  1  controller accepts a toss this cycle.
REQ-012 busy  output  1  game in progress (state PLAY).
REQ-013 cur_player  output  2  player whose toss is accepted next.
REQ-014 cur_streak  output  STREAK_W  current streak of cur_player.
REQ-015 round_cnt  output  8  completed full rounds in this game.
REQ-016 win_valid  output  1  one-cycle pulse announcing a winner.
REQ-017 winner  output  2  winning player index; held until the next accepted start.

Function
REQ-018 States: IDLE, PLAY, DONE; registered state; one toss is consumed per cycle at most.
REQ-019 IDLE: toss_ready=0, busy=0; start=1 latches cfg_players and cfg_target, clears all streaks, cur_player and round_cnt, and enters PLAY next cycle.
REQ-020 start is ignored in PLAY and DONE.
REQ-021 PLAY: toss_ready = !abort (combinational); a toss is accepted when toss_valid && toss_ready.
REQ-022 Accepted head: streak[cur_player] increments, saturating at 2^STREAK_W-1; accepted tail: streak[cur_player] clears to 0.
REQ-023 Win check uses the post-update streak: if it equals the effective target, then winner<=cur_player, state<=DONE, and cur_player, round_cnt and streaks are unchanged that cycle.
REQ-024 No win: cur_player advances by 1 and wraps to 0 after cfg_players; on the wrap, round_cnt increments, saturating at 255.
REQ-025 No toss accepted: all counters hold.
REQ-026 abort in PLAY: no toss is consumed, state goes to IDLE next cycle, win_valid stays 0, and winner keeps its prior value.
REQ-027 DONE lasts exactly one cycle, with win_valid=1, toss_ready=0 and busy=0; the next state is IDLE.
REQ-028 cur_streak always reflects streak[cur_player].
REQ-029 With cfg_players=0, cur_player stays 0 and round_cnt increments on every non-winning accepted toss.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, all streaks=0, cur_player=0, round_cnt=0, winner=0, win_valid=0, toss_ready=0 and busy=0; assertion mid-game discards that game.
REQ-031 Deassertion is synchronous to clk at the integration level; the block needs no internal synchronizer.

Structure
REQ-032 Shared package toss_pkg holds the state encoding (IDLE=0, PLAY=1, DONE=2), MAX_PLAYERS, STREAK_W and the round counter width.
REQ-033 One sub-module, streak_cnt, is instantiated MAX_PLAYERS times; it has a saturating STREAK_W counter with inc, clr and async rst_n.
REQ-034 The FSM, player pointer, round counter and win compare live in toss_game_ctrl.

Verification
REQ-035 Scenario 1: cfg_players=0, cfg_target=3, tosses H,H,H -> win_valid pulses exactly 1 cycle after the third acceptance, winner=0, round_cnt=2.
REQ-036 Scenario 2: cfg_players=1, target=2, tosses P0:H, P1:H, P0:T, P1:H -> winner=1, round_cnt=1, and P0's streak is 0 at win.
REQ-037 Scenario 3: cfg_players=3, target=0, first toss H by P0 -> immediate win, winner=0 (target 0 is treated as 1).
REQ-038 Scenario 4: abort and toss_valid high in the same PLAY cycle -> toss_ready=0, streak unchanged, IDLE next cycle, no win_valid.
REQ-039 Scenario 5: rst_n pulsed low mid-game with streak[2]=2 -> all outputs reach reset values immediately; a new start shows cur_streak=0.
REQ-040 Scenario 6: start asserted during PLAY and DONE -> ignored; cfg changes have no effect until the next IDLE start.

Source files
------------

// File: rtl/toss_pkg.sv
// rtl/toss_pkg.sv - shared types and sizing for the toss game controller
// Holds the FSM state encoding and the default sizes used by
// toss_game_ctrl and streak_cnt.
package toss_pkg;

   localparam int TOSS_MAX_PLAYERS = 4;
   localparam int TOSS_STREAK_W    = 3;
   localparam int TOSS_ROUND_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/streak_cnt.sv
// rtl/streak_cnt.sv - saturating per-player streak counter
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one, holding at the all-ones value
//   clr        : clear to zero (wins over inc)
//   cnt        : current streak
module streak_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/toss_game_ctrl.sv
// rtl/toss_game_ctrl.sv - coin toss streak game controller
// Players toss in turn; the first to reach cfg_target consecutive heads wins.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start, abort             : begin a game (IDLE only) / end it without a winner
//   cfg_players, cfg_target  : players-1 and heads needed, latched on start
//   toss_valid, toss         : toss handshake and result (1 = head)
//   toss_ready               : a toss is accepted this cycle
//   busy                     : game in progress
//   cur_player, cur_streak   : next player to toss and that player's streak
//   round_cnt                : completed full rounds, saturating
//   win_valid, winner        : one-cycle win pulse and held winner index
module toss_game_ctrl
   import toss_pkg::*;
#(
   parameter int MAX_PLAYERS = TOSS_MAX_PLAYERS,
   parameter int STREAK_W    = TOSS_STREAK_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [1:0]              cfg_players,
   input  logic [STREAK_W-1:0]     cfg_target,
   input  logic                    toss_valid,
   input  logic                    toss,
   output logic                    toss_ready,
   output logic                    busy,
   output logic [1:0]              cur_player,
   output logic [STREAK_W-1:0]     cur_streak,
   output logic [TOSS_ROUND_W-1:0] round_cnt,
   output logic                    win_valid,
   output logic [1:0]              winner
);

   state_t                 state;
   logic [1:0]             players_q;
   logic [STREAK_W-1:0]    target_q;
   logic [STREAK_W-1:0]    streak [MAX_PLAYERS];
   logic [MAX_PLAYERS-1:0] inc;
   logic [MAX_PLAYERS-1:0] clr;
   logic                   accept;
   logic [STREAK_W-1:0]    head_next;
   logic                   win;

   for (genvar i = 0; i < MAX_PLAYERS; i++) begin : g_streak
      streak_cnt #(.W(STREAK_W)) u_streak (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc[i]),
         .clr   (clr[i]),
         .cnt   (streak[i])
      );
   end

   assign toss_ready = (state == ST_PLAY) && !abort;
   assign busy       = (state == ST_PLAY);
   assign win_valid  = (state == ST_DONE);
   assign accept     = toss_valid && toss_ready;
   assign cur_streak = streak[cur_player];

   // The win compare must see the value the counter is about to take,
   // including saturation, so the same head that completes the streak wins.
   assign head_next = (cur_streak == {STREAK_W{1'b1}}) ? cur_streak
                                                      : cur_streak + STREAK_W'(1);
   assign win       = accept && toss && (head_next == target_q);

   always_comb begin
      inc = '0;
      clr = '0;
      if ((state == ST_IDLE) && start) begin
         clr = '1;
      end else if (accept) begin
         if (toss) inc[cur_player] = 1'b1;
         else      clr[cur_player] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         players_q  <= '0;
         target_q   <= STREAK_W'(1);
         cur_player <= '0;
         round_cnt  <= '0;
         winner     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  players_q  <= cfg_players;
                  // A target of zero would never match a post-head streak.
                  target_q   <= (cfg_target == '0) ? STREAK_W'(1) : cfg_target;
                  cur_player <= '0;
                  round_cnt  <= '0;
                  state      <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (accept) begin
                  if (win) begin
                     winner <= cur_player;
                     state  <= ST_DONE;
                  end else if (cur_player == players_q) begin
                     cur_player <= '0;
                     if (round_cnt != {TOSS_ROUND_W{1'b1}})
                        round_cnt <= round_cnt + TOSS_ROUND_W'(1);
                  end else begin
                     cur_player <= cur_player + 2'd1;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_toss_game_ctrl.sv
// tb/tb_toss_game_ctrl.sv - directed self-checking bench for toss_game_ctrl
module tb_toss_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] cfg_players = '0;
   logic [2:0] cfg_target = '0;
   logic       toss_valid = 1'b0;
   logic       toss = 1'b0;
   logic       toss_ready;
   logic       busy;
   logic [1:0] cur_player;
   logic [2:0] cur_streak;
   logic [7:0] round_cnt;
   logic       win_valid;
   logic [1:0] winner;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   toss_game_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .cfg_players (cfg_players),
      .cfg_target  (cfg_target),
      .toss_valid  (toss_valid),
      .toss        (toss),
      .toss_ready  (toss_ready),
      .busy        (busy),
      .cur_player  (cur_player),
      .cur_streak  (cur_streak),
      .round_cnt   (round_cnt),
      .win_valid   (win_valid),
      .winner      (winner)
   );

   typedef struct {
      string      name;
      logic       start, abort;
      logic [1:0] pl;
      logic [2:0] tg;
      logic       tv, ts;
      logic       e_rdy, e_busy;
      logic [1:0] e_pl;
      logic [2:0] e_st;
      logic       chk_st;
      logic [7:0] e_rnd;
      logic       e_win;
      logic [1:0] e_wnr;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(string n, logic s, logic a, logic [1:0] p, logic [2:0] t,
                               logic tv, logic ts, logic rdy, logic bsy, logic [1:0] epl,
                               logic [2:0] est, logic cst, logic [7:0] ernd, logic ew,
                               logic [1:0] ewn);
      vec_t r;
      r.name = n; r.start = s; r.abort = a; r.pl = p; r.tg = t; r.tv = tv; r.ts = ts;
      r.e_rdy = rdy; r.e_busy = bsy; r.e_pl = epl; r.e_st = est; r.chk_st = cst;
      r.e_rnd = ernd; r.e_win = ew; r.e_wnr = ewn;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(vec_t v);
      start = v.start; abort = v.abort; cfg_players = v.pl; cfg_target = v.tg;
      toss_valid = v.tv; toss = v.ts;
      @(posedge clk); #1;
      chk({v.name, ".toss_ready"}, 32'(toss_ready), 32'(v.e_rdy));
      chk({v.name, ".busy"},       32'(busy),       32'(v.e_busy));
      chk({v.name, ".cur_player"}, 32'(cur_player), 32'(v.e_pl));
      if (v.chk_st) chk({v.name, ".cur_streak"}, 32'(cur_streak), 32'(v.e_st));
      chk({v.name, ".round_cnt"},  32'(round_cnt),  32'(v.e_rnd));
      chk({v.name, ".win_valid"},  32'(win_valid),  32'(v.e_win));
      chk({v.name, ".winner"},     32'(winner),     32'(v.e_wnr));
   endtask

   task automatic begin_game(logic [1:0] p, logic [2:0] t);
      start = 1'b1; cfg_players = p; cfg_target = t;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_toss(logic b);
      toss_valid = 1'b1; toss = b;
      @(posedge clk); #1;
      toss_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, ".toss_ready"}, 32'(toss_ready), 32'd0);
      chk({tag, ".busy"},       32'(busy),       32'd0);
      chk({tag, ".cur_player"}, 32'(cur_player), 32'd0);
      chk({tag, ".cur_streak"}, 32'(cur_streak), 32'd0);
      chk({tag, ".round_cnt"},  32'(round_cnt),  32'd0);
      chk({tag, ".win_valid"},  32'(win_valid),  32'd0);
      chk({tag, ".winner"},     32'(winner),     32'd0);
   endtask

   initial begin
      //            name             st ab pl tg tv ts | rdy bsy pl st cs rnd win wnr
      vecs[0]  = mk("s1_start",       1, 0, 0, 3, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0);
      vecs[1]  = mk("s1_h1",          0, 0, 0, 3, 1, 1,  1, 1, 0, 1, 1, 1, 0, 0);
      vecs[2]  = mk("s1_h2",          0, 0, 0, 3, 1, 1,  1, 1, 0, 2, 1, 2, 0, 0);
      vecs[3]  = mk("s1_h3_win",      0, 0, 0, 3, 1, 1,  0, 0, 0, 0, 0, 2, 1, 0);
      vecs[4]  = mk("s1_idle",        0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0);
      vecs[5]  = mk("s2_start",       1, 0, 1, 2, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0);
      vecs[6]  = mk("s2_p0h",         0, 0, 1, 2, 1, 1,  1, 1, 1, 0, 1, 0, 0, 0);
      vecs[7]  = mk("s2_p1h",         0, 0, 1, 2, 1, 1,  1, 1, 0, 1, 1, 1, 0, 0);
      vecs[8]  = mk("s2_p0t",         0, 0, 1, 2, 1, 0,  1, 1, 1, 1, 1, 1, 0, 0);
      vecs[9]  = mk("s2_p1h_win",     0, 0, 1, 2, 1, 1,  0, 0, 1, 0, 0, 1, 1, 1);
      vecs[10] = mk("s2_idle",        0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 1);
      vecs[11] = mk("s3_start_t0",    1, 0, 3, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 1);
      vecs[12] = mk("s3_h_win",       1, 0, 0, 5, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0);
      vecs[13] = mk("s6_start_done",  1, 0, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      vecs[14] = mk("s6_idle_hold",   0, 0, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      vecs[15] = mk("s6_start",       1, 0, 1, 2, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0);
      vecs[16] = mk("s6_start_play",  1, 0, 0, 1, 1, 1,  1, 1, 1, 0, 1, 0, 0, 0);
      vecs[17] = mk("s6_p1t",         0, 0, 0, 1, 1, 0,  1, 1, 0, 1, 1, 1, 0, 0);

      #2;
      chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) step(vecs[i]);

      // Abort together with a valid toss: nothing consumed, back to IDLE, no win.
      abort = 1'b1; toss_valid = 1'b1; toss = 1'b1;
      #1;
      chk("s4.toss_ready", 32'(toss_ready), 32'd0);
      @(posedge clk); #1;
      chk("s4.busy",       32'(busy),       32'd0);
      chk("s4.win_valid",  32'(win_valid),  32'd0);
      chk("s4.cur_player", 32'(cur_player), 32'd0);
      chk("s4.cur_streak", 32'(cur_streak), 32'd1);
      chk("s4.winner",     32'(winner),     32'd0);
      abort = 1'b0; toss_valid = 1'b0;
      @(posedge clk); #1;
      chk("s4.win_after",  32'(win_valid),  32'd0);
      chk("s4.idle_busy",  32'(busy),       32'd0);

      // Mid-game reset with player 2 on a streak of two.
      begin_game(2'd3, 3'd7);
      do_toss(0); do_toss(0); do_toss(1); do_toss(0);
      do_toss(0); do_toss(0); do_toss(1); do_toss(0);
      do_toss(0); do_toss(0);
      chk("s5.pre_player", 32'(cur_player), 32'd2);
      chk("s5.pre_streak", 32'(cur_streak), 32'd2);
      chk("s5.pre_round",  32'(round_cnt),  32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("s5.async");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      begin_game(2'd3, 3'd2);
      chk("s5.new_busy",   32'(busy),       32'd1);
      chk("s5.new_streak", 32'(cur_streak), 32'd0);
      do_toss(0); do_toss(0);
      chk("s5.p2_player",  32'(cur_player), 32'd2);
      chk("s5.p2_streak",  32'(cur_streak), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
